// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin arbiter that time-shares one combinational ALU between
// two requesters, holding operands in registers and the result until it is taken.
module alu_share_arb #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [WIDTH-1:0] i_req0_a,
    input  logic [WIDTH-1:0] i_req0_b,
    input  logic [2:0]       i_req0_op,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [WIDTH-1:0] i_req1_a,
    input  logic [WIDTH-1:0] i_req1_b,
    input  logic [2:0]       i_req1_op,
    output logic [WIDTH-1:0] o_alu_src_a,
    output logic [WIDTH-1:0] o_alu_src_b,
    output logic [2:0]       o_alu_control,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic             i_alu_zero,
    output logic             o_rsp0_valid,
    input  logic             i_rsp0_ready,
    output logic             o_rsp1_valid,
    input  logic             i_rsp1_ready,
    output logic [WIDTH-1:0] o_rsp_result,
    output logic             o_rsp_zero,
    output logic             o_rsp_err,
    output logic             o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_rr_ptr;
    logic             r_owner;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [2:0]       r_op_code;
    logic [WIDTH-1:0] r_res;
    logic             r_zr;
    logic             r_err;

    logic w_grant;
    logic w_grant_valid;
    logic w_accept;
    logic w_owner_ready;
    logic w_illegal;

    // A lone requester wins outright; rr_ptr only breaks ties.
    assign w_grant       = (i_req0_valid & i_req1_valid) ? r_rr_ptr : i_req1_valid;
    assign w_grant_valid = w_grant ? i_req1_valid : i_req0_valid;
    assign w_accept      = (r_state == S_IDLE) & w_grant_valid;
    assign w_owner_ready = r_owner ? i_rsp1_ready : i_rsp0_ready;
    assign w_illegal     = r_op_code[2] & r_op_code[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: default first so every path assigns w_next_state and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_RESP;
            S_RESP:  if (w_owner_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: operand registers are reset because they drive the ALU ports directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr  <= 1'b0;
            r_owner   <= 1'b0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op_code <= 3'b000;
            r_res     <= '0;
            r_zr      <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op_a    <= w_grant ? i_req1_a  : i_req0_a;
                r_op_b    <= w_grant ? i_req1_b  : i_req0_b;
                r_op_code <= w_grant ? i_req1_op : i_req0_op;
                r_owner   <= w_grant;
                r_rr_ptr  <= ~w_grant;
            end
            if (r_state == S_EXEC) begin
                r_res <= w_illegal ? '0 : i_alu_result;
                r_zr  <= i_alu_zero;
                r_err <= w_illegal;
            end
        end
    end

    always_comb begin
        o_req0_ready  = 1'b0;
        o_req1_ready  = 1'b0;
        o_alu_control = 3'b000;
        o_rsp0_valid  = 1'b0;
        o_rsp1_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_req0_ready = ~rst & ~w_grant;
                o_req1_ready = ~rst & w_grant;
            end
            S_EXEC: o_alu_control = r_op_code;
            S_RESP: begin
                o_rsp0_valid = ~r_owner;
                o_rsp1_valid = r_owner;
            end
            default: ;
        endcase
    end

    assign o_alu_src_a  = r_op_a;
    assign o_alu_src_b  = r_op_b;
    assign o_rsp_result = r_res;
    assign o_rsp_zero   = r_zr;
    assign o_rsp_err    = r_err;
    assign o_busy       = (r_state != S_IDLE);

endmodule
